// File: rtl/mem_access_stage_pkg.sv
// Op codes and op classification shared by the MEM stage and its lane aligner.
package mem_access_stage_pkg;

  localparam int unsigned ALUOP_W = 8;

  localparam logic [ALUOP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  function automatic logic op_is_load(input logic [ALUOP_W-1:0] op);
    return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
  endfunction

  function automatic logic op_is_store(input logic [ALUOP_W-1:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic op_misaligned(input logic [ALUOP_W-1:0] op,
                                         input logic [1:0]         addr_lo);
    logic bad;
    bad = 1'b0;
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: bad = addr_lo[0];
      EXE_LW_OP, EXE_SW_OP:             bad = |addr_lo;
      default:                          bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane alignment: store data/mask packing and load byte/half extract with extension.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [1:0]         addr_lo,
  input  logic [31:0]        rt_data,
  input  logic [31:0]        rdata,
  output logic [31:0]        st_wdata,
  output logic [3:0]         st_wmask,
  output logic [31:0]        ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    st_wdata = '0;
    st_wmask = '0;
    case (aluop)
      EXE_SB_OP: begin
        st_wdata = {4{rt_data[7:0]}};
        st_wmask = 4'b0001 << addr_lo;
      end
      EXE_SH_OP: begin
        st_wdata = {2{rt_data[15:0]}};
        st_wmask = 4'b0011 << {addr_lo[1], 1'b0};
      end
      EXE_SW_OP: begin
        st_wdata = rt_data;
        st_wmask = 4'hF;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (aluop)
      EXE_LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      EXE_LBU_OP: ld_data = {24'b0, ld_byte};
      EXE_LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
      EXE_LHU_OP: ld_data = {16'b0, ld_half};
      EXE_LW_OP:  ld_data = rdata;
      default:    ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: sequences loads/stores over the dmem req/gnt/rvalid port.
// Build option MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of issuing.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          mem_reg_waddr,
  input  logic                mem_we,
  input  logic [DATA_W-1:0]   mem_reg_wdata,
  input  logic [ADDR_W-1:0]   mem_mem_addr,
  input  logic [ALUOP_W-1:0]  mem_aluop,
  input  logic [DATA_W-1:0]   mem_rt_data,
  input  logic [5:0]          stall,
  output logic                dmem_req,
  output logic                dmem_wr,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [3:0]          dmem_wmask,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic [4:0]          wb_reg_waddr,
  output logic                wb_we,
  output logic [DATA_W-1:0]   wb_reg_wdata,
  output logic                stallreq_mem,
  output logic                excp_misalign
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] load_q;
  logic              is_ld, is_st, is_mem, misalign, go;
  logic              req_c, stall_c, we_c;
  logic [DATA_W-1:0] wdata_c;
  logic [31:0]       st_wdata, ld_data;
  logic [3:0]        st_wmask;
  logic              unused_stall;

  assign is_ld  = op_is_load(mem_aluop);
  assign is_st  = op_is_store(mem_aluop);
  assign is_mem = is_ld | is_st;
  assign go     = is_mem & ~misalign;

  assign unused_stall = ^{stall[5], stall[3:0]};

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign      = op_misaligned(mem_aluop, mem_mem_addr[1:0]);
  assign excp_misalign = rst && (state_q == ST_IDLE) && is_mem && misalign;
`else
  assign misalign      = 1'b0;
  assign excp_misalign = 1'b0;
`endif

  mem_lane_align u_align (
    .aluop    (mem_aluop),
    .addr_lo  (mem_mem_addr[1:0]),
    .rt_data  (mem_rt_data),
    .rdata    (dmem_rdata),
    .st_wdata (st_wdata),
    .st_wmask (st_wmask),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    we_c    = mem_we;
    wdata_c = mem_reg_wdata;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          we_c    = 1'b0;
          if (dmem_gnt) state_d = is_st ? ST_DONE : ST_WAIT;
          else          state_d = ST_REQ;
        end else if (is_mem) begin
          we_c = 1'b0;
        end
      end
      ST_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        we_c    = 1'b0;
        if (dmem_gnt) state_d = is_st ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        we_c    = 1'b0;
        if (dmem_rvalid) state_d = ST_DONE;
      end
      default: begin
        if (is_ld) wdata_c = load_q;
        if (!stall[4]) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_WAIT && dmem_rvalid) load_q <= ld_data;
    end
  end

  // Outputs are gated by rst so an abandoned access drops the port the moment reset asserts.
  assign dmem_req     = rst && req_c;
  assign dmem_wr      = dmem_req && is_st;
  assign dmem_addr    = dmem_req ? {mem_mem_addr[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata   = dmem_req ? st_wdata : '0;
  assign dmem_wmask   = dmem_req ? st_wmask : '0;
  assign wb_reg_waddr = rst ? mem_reg_waddr : '0;
  assign wb_we        = rst && we_c;
  assign wb_reg_wdata = rst ? wdata_c : '0;
  assign stallreq_mem = rst && stall_c;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level model plus directed vectors.
`timescale 1ns/1ps
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  mem_reg_waddr = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_reg_wdata = '0;
  logic [31:0] mem_mem_addr = '0;
  logic [7:0]  mem_aluop = '0;
  logic [31:0] mem_rt_data = '0;
  logic [5:0]  stall = '0;
  logic        dmem_req, dmem_wr;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [4:0]  wb_reg_waddr;
  logic        wb_we;
  logic [31:0] wb_reg_wdata;
  logic        stallreq_mem, excp_misalign;

  always #5 clk = ~clk;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mem_access_stage #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_reg_waddr(mem_reg_waddr), .mem_we(mem_we), .mem_reg_wdata(mem_reg_wdata),
    .mem_mem_addr(mem_mem_addr), .mem_aluop(mem_aluop), .mem_rt_data(mem_rt_data),
    .stall(stall),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_reg_waddr(wb_reg_waddr), .wb_we(wb_we), .wb_reg_wdata(wb_reg_wdata),
    .stallreq_mem(stallreq_mem), .excp_misalign(excp_misalign)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- model: access size in bytes, lane arithmetic, extension ----
  function automatic int unsigned op_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
      EXE_LW_OP, EXE_SW_OP:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit op_st(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic bit op_sx(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP);
  endfunction

  function automatic int unsigned first_lane(input int unsigned sz, input logic [31:0] addr);
    if (sz == 4) return 0;
    if (sz == 2) return addr[1] ? 2 : 0;
    return {30'b0, addr[1:0]};
  endfunction

  function automatic bit is_trap(input logic [7:0] op, input logic [31:0] addr);
    int unsigned sz;
    sz = op_size(op);
    return TRAP && (((sz == 2) && addr[0]) || ((sz == 4) && (addr[1:0] != 2'b00)));
  endfunction

  function automatic logic [3:0] exp_mask(input logic [7:0] op, input logic [31:0] addr);
    int unsigned sz;
    int unsigned m;
    sz = op_size(op);
    if (!op_st(op)) return 4'h0;
    m = ((32'd1 << sz) - 1) << first_lane(sz, addr);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] rt);
    case (op_size(op))
      1:       return {24'b0, rt[7:0]} * 32'h0101_0101;
      2:       return {16'b0, rt[15:0]} * 32'h0001_0001;
      default: return rt;
    endcase
  endfunction

  function automatic logic [31:0] m_extend(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned sz;
    logic [31:0] v;
    sz = op_size(op);
    v  = rdata >> (8 * first_lane(sz, addr));
    if (sz == 1) begin
      v = v & 32'h0000_00FF;
      if (op_sx(op) && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'h0000_FFFF;
      if (op_sx(op) && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Transaction progress: accepted by memory, finished (data in hand / store accepted).
  logic        m_issued = 1'b0;
  logic        m_done   = 1'b0;
  logic [31:0] m_ld     = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_issued <= 1'b0;
      m_done   <= 1'b0;
    end else if (m_done) begin
      if (!stall[4]) begin
        m_done   <= 1'b0;
        m_issued <= 1'b0;
      end
    end else if (op_size(mem_aluop) != 0 && !is_trap(mem_aluop, mem_mem_addr)) begin
      if (!m_issued) begin
        if (dmem_gnt) begin
          m_issued <= 1'b1;
          if (op_st(mem_aluop)) m_done <= 1'b1;
        end
      end else if (dmem_rvalid) begin
        m_done <= 1'b1;
        m_ld   <= m_extend(mem_aluop, mem_mem_addr, dmem_rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      cmp("rst_req", dmem_req, 0);
      cmp("rst_stallreq", stallreq_mem, 0);
      cmp("rst_wb_we", wb_we, 0);
      cmp("rst_wb_waddr", wb_reg_waddr, 0);
      cmp("rst_wb_wdata", wb_reg_wdata, 0);
      cmp("rst_excp", excp_misalign, 0);
    end else if (op_size(mem_aluop) == 0) begin
      cmp("pass_req", dmem_req, 0);
      cmp("pass_stallreq", stallreq_mem, 0);
      cmp("pass_wb_we", wb_we, mem_we);
      cmp("pass_excp", excp_misalign, 0);
      if (mem_we) begin
        cmp("pass_wb_waddr", wb_reg_waddr, mem_reg_waddr);
        cmp("pass_wb_wdata", wb_reg_wdata, mem_reg_wdata);
      end
    end else if (is_trap(mem_aluop, mem_mem_addr)) begin
      cmp("trap_req", dmem_req, 0);
      cmp("trap_stallreq", stallreq_mem, 0);
      cmp("trap_wb_we", wb_we, 0);
      cmp("trap_excp", excp_misalign, 1);
    end else if (!m_done) begin
      cmp("busy_req", dmem_req, !m_issued);
      cmp("busy_stallreq", stallreq_mem, 1);
      cmp("busy_wb_we", wb_we, 0);
      cmp("busy_excp", excp_misalign, 0);
      if (!m_issued) begin
        cmp("req_wr", dmem_wr, op_st(mem_aluop));
        cmp("req_addr", dmem_addr, mem_mem_addr & 32'hFFFF_FFFC);
        cmp("req_mask", dmem_wmask, exp_mask(mem_aluop, mem_mem_addr));
        if (op_st(mem_aluop)) cmp("req_wdata", dmem_wdata, exp_wdata(mem_aluop, mem_rt_data));
      end
    end else begin
      cmp("done_req", dmem_req, 0);
      cmp("done_stallreq", stallreq_mem, 0);
      cmp("done_wb_we", wb_we, mem_we);
      cmp("done_excp", excp_misalign, 0);
      if (mem_we) begin
        cmp("done_wb_waddr", wb_reg_waddr, mem_reg_waddr);
        cmp("done_wb_wdata", wb_reg_wdata, op_st(mem_aluop) ? mem_reg_wdata : m_ld);
      end
    end
  end

  // ---- stimulus ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [4:0] wa, input logic [31:0] wd);
    mem_aluop     = EXE_ADD_OP;
    mem_reg_waddr = wa;
    mem_we        = 1'b1;
    mem_reg_wdata = wd;
    mem_mem_addr  = '0;
    mem_rt_data   = '0;
  endtask

  // One access: gnt after gdly cycles, rvalid the cycle after gnt (loads), DONE held hold cycles.
  task automatic txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                     input logic [31:0] rdata, input int unsigned gdly, input int unsigned hold,
                     output int unsigned req_cnt, output logic [3:0] req_mask,
                     output logic [31:0] req_wdata, output logic [31:0] req_addr,
                     output logic [31:0] first_done, output logic [31:0] last_done,
                     output logic done_stallreq);
    req_cnt = 0; req_mask = '0; req_wdata = '0; req_addr = '0;
    first_done = '0; last_done = '0; done_stallreq = 1'b0;
    mem_aluop     = op;
    mem_mem_addr  = addr;
    mem_rt_data   = rt;
    mem_reg_waddr = 5'd9;
    mem_we        = !op_st(op);
    mem_reg_wdata = 32'h0BAD_0000 | addr;
    for (int i = 0; i <= int'(gdly); i++) begin
      dmem_gnt = (i == int'(gdly));
      @(negedge clk);
      if (dmem_req) req_cnt++;
      if (i == 0) begin
        req_mask = dmem_wmask; req_wdata = dmem_wdata; req_addr = dmem_addr;
      end
      step();
    end
    dmem_gnt = 1'b0;
    if (!op_st(op)) begin
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      step();
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h5555_AAAA;
    end
    for (int h = 0; h <= int'(hold); h++) begin
      stall = (h < int'(hold)) ? 6'b01_1111 : 6'b00_0000;
      @(negedge clk);
      if (h == 0) begin
        first_done    = wb_reg_wdata;
        done_stallreq = stallreq_mem;
      end
      last_done = wb_reg_wdata;
      step();
    end
    stall = '0;
  endtask

  int unsigned rc;
  logic [3:0]  rm;
  logic [31:0] rw, ra, fd, ld;
  logic        ds;

  initial begin
    @(negedge clk);
    cmp("reset_wb_we", wb_we, 0);
    step();
    rst = 1'b1;

    // ALU op passes straight through
    set_alu(5'd5, 32'h0000_1234);
    @(negedge clk);
    cmp("t1_waddr", wb_reg_waddr, 5);
    cmp("t1_we", wb_we, 1);
    cmp("t1_wdata", wb_reg_wdata, 32'h0000_1234);
    cmp("t1_stallreq", stallreq_mem, 0);
    cmp("t1_req", dmem_req, 0);
    step();

    txn(EXE_LB_OP, 32'h0000_0103, '0, 32'h80FF_0000, 0, 0, rc, rm, rw, ra, fd, ld, ds);
    cmp("t2_lb_data", fd, 32'hFFFF_FF80);
    cmp("t2_req_cycles", rc, 1);
    cmp("t2_addr", ra, 32'h0000_0100);

    txn(EXE_SH_OP, 32'h0000_0202, 32'h0000_ABCD, '0, 3, 0, rc, rm, rw, ra, fd, ld, ds);
    cmp("t3_req_cycles", rc, 4);
    cmp("t3_mask", rm, 4'b1100);
    cmp("t3_wdata", rw, 32'hABCD_ABCD);
    cmp("t3_done_stallreq", ds, 0);

    txn(EXE_LHU_OP, 32'h0000_0000, '0, 32'h1234_8765, 1, 2, rc, rm, rw, ra, fd, ld, ds);
    cmp("t4_first_done", fd, 32'h0000_8765);
    cmp("t4_last_done", ld, 32'h0000_8765);
    set_alu(5'd7, 32'h0000_0077);
    @(negedge clk);
    cmp("t4_idle_stallreq", stallreq_mem, 0);
    step();

    txn(EXE_SB_OP, 32'h0000_0101, 32'h0000_005A, '0, 0, 0, rc, rm, rw, ra, fd, ld, ds);
    cmp("sb_mask", rm, 4'b0010);
    cmp("sb_wdata", rw, 32'h5A5A_5A5A);
    txn(EXE_LBU_OP, 32'h0000_0102, '0, 32'h00AB_0000, 2, 1, rc, rm, rw, ra, fd, ld, ds);
    cmp("lbu_data", fd, 32'h0000_00AB);
    txn(EXE_SW_OP, 32'h0000_0010, 32'hCAFE_F00D, '0, 1, 0, rc, rm, rw, ra, fd, ld, ds);
    cmp("sw_mask", rm, 4'hF);
    cmp("sw_wdata", rw, 32'hCAFE_F00D);
    txn(EXE_LH_OP, 32'h0000_0002, '0, 32'h8001_1234, 0, 0, rc, rm, rw, ra, fd, ld, ds);
    cmp("lh_data", fd, 32'hFFFF_8001);

    // reset asserted while a load waits for data
    mem_aluop = EXE_LB_OP; mem_mem_addr = 32'h0000_0100; mem_we = 1'b1; mem_reg_waddr = 5'd3;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    @(negedge clk);
    cmp("t5_wait_stallreq", stallreq_mem, 1);
    cmp("t5_wait_req", dmem_req, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    cmp("t5_rst_req", dmem_req, 0);
    cmp("t5_rst_stallreq", stallreq_mem, 0);
    cmp("t5_rst_wb_we", wb_we, 0);
    step();
    set_alu(5'd4, 32'h0000_0044);
    step();
    rst = 1'b1;
    @(negedge clk);
    cmp("t5_post_we", wb_we, 1);
    step();
    txn(EXE_LB_OP, 32'h0000_0100, '0, 32'h0000_007F, 0, 0, rc, rm, rw, ra, fd, ld, ds);
    cmp("t5_idle_req_cycles", rc, 1);
    cmp("t5_reload_data", fd, 32'h0000_007F);

`ifdef MEM_MISALIGN_TRAP_EN
    mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h0000_0006; mem_we = 1'b1; mem_reg_waddr = 5'd2;
    @(negedge clk);
    cmp("t6_excp", excp_misalign, 1);
    cmp("t6_req", dmem_req, 0);
    cmp("t6_wb_we", wb_we, 0);
    cmp("t6_stallreq", stallreq_mem, 0);
    step();
    set_alu(5'd2, 32'h0000_0022);
    @(negedge clk);
    cmp("t6_excp_gone", excp_misalign, 0);
    step();
`else
    txn(EXE_LW_OP, 32'h0000_0006, '0, 32'hDEAD_BEEF, 0, 0, rc, rm, rw, ra, fd, ld, ds);
    cmp("t6_lw_addr", ra, 32'h0000_0004);
    cmp("t6_lw_data", fd, 32'hDEAD_BEEF);
    txn(EXE_LH_OP, 32'h0000_0003, '0, 32'h8001_1234, 0, 0, rc, rm, rw, ra, fd, ld, ds);
    cmp("t6_lh_odd_data", fd, 32'hFFFF_8001);
    cmp("t6_excp_tied", excp_misalign, 0);
`endif

    set_alu(5'd1, 32'h0000_0011);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
